// File: rtl/speech_seq_pkg.sv
// speech_seq_pkg: state encoding, default index limits and the track address helper
package speech_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SETTLE, PLAY, GAP, DONE} state_t;
  localparam int DEF_NUM_TRACKS = 30;
  localparam int DEF_SKIP_IDX = 30;
  function automatic logic [63:0] track_base(input logic [31:0] idx, input logic [31:0] base,
                                             input logic [31:0] len);
    return {32'd0, base} + {32'd0, idx} * {32'd0, len};
  endfunction
endpackage

// File: rtl/seq_fifo.sv
// seq_fifo: synchronous track-index FIFO; push dropped when full, pop ignored when empty, flush empties it
module seq_fifo #(
  parameter int SEQ_DEPTH = 8,
  parameter int IDX_W = 5
) (
  input  logic clock,
  input  logic reset_b,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [IDX_W-1:0] din,
  output logic [IDX_W-1:0] dout,
  output logic [$clog2(SEQ_DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(SEQ_DEPTH);
  logic [IDX_W-1:0] r_mem [SEQ_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_wr, w_rd;
  assign count = r_wp - r_rp;
  assign full = count == (AW+1)'(SEQ_DEPTH);
  assign empty = r_wp == r_rp;
  assign dout = r_mem[r_rp[AW-1:0]];
  assign w_wr = push && !full;
  assign w_rd = pop && !empty;
  always_ff @(posedge clock)
    if (!reset_b || flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= r_wp + (AW+1)'(w_wr);
      r_rp <= r_rp + (AW+1)'(w_rd);
    end
  always_ff @(posedge clock)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= din;
endmodule

// File: rtl/speech_sequencer.sv
// speech_sequencer: plays queued track indices from flash, TRACK_LENGTH samples per track on sample_tick.
// Define SPEECH_SEQ_GAP_EN to insert GAP_SAMPLES silent samples between consecutive tracks.
module speech_sequencer import speech_seq_pkg::*; #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int SAMPLE_W = 8,
  parameter int IDX_W = 5,
  parameter int NUM_TRACKS = DEF_NUM_TRACKS,
  parameter int SKIP_IDX = DEF_SKIP_IDX,
  parameter int TRACK_LENGTH = 48000,
  parameter int BASE_ADDR = 1,
  parameter int SEQ_DEPTH = 8,
  parameter int SETTLE_CYC = 4
`ifdef SPEECH_SEQ_GAP_EN
  , parameter int GAP_SAMPLES = 2400
`endif
) (
  input  logic clock,
  input  logic reset_b,
  input  logic push,
  input  logic [IDX_W-1:0] push_idx,
  output logic full,
  output logic [$clog2(SEQ_DEPTH):0] count,
  input  logic start,
  input  logic abort,
  input  logic sample_tick,
  output logic [ADDR_W-1:0] raddr,
  output logic doread,
  input  logic [DATA_W-1:0] frdata,
  input  logic busy,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic sample_valid,
  output logic playing,
  output logic [IDX_W-1:0] cur_idx,
  output logic done,
  output logic err
);
  localparam int RW = $clog2(TRACK_LENGTH + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  state_t r_state;
  logic [RW-1:0] r_rem;
  logic [SW-1:0] r_set;
  logic [ADDR_W-1:0] r_raddr;
  logic [SAMPLE_W-1:0] r_sample;
  logic [IDX_W-1:0] r_cur;
  logic r_doread, r_valid, r_done, r_err;
  logic [IDX_W-1:0] w_head;
  logic w_empty, w_full, w_pop, w_skip, w_bad, w_unused;
`ifdef SPEECH_SEQ_GAP_EN
  localparam int GW = $clog2(GAP_SAMPLES + 1);
  logic [GW-1:0] r_gap;
`endif
  seq_fifo #(.SEQ_DEPTH(SEQ_DEPTH), .IDX_W(IDX_W)) u_fifo (
    .clock(clock), .reset_b(reset_b), .flush(abort), .push(push && !abort), .pop(w_pop),
    .din(push_idx), .dout(w_head), .count(count), .full(w_full), .empty(w_empty)
  );
  assign w_pop = r_state == FETCH && !w_empty && !abort;
  assign w_skip = 32'(w_head) == 32'(SKIP_IDX);
  assign w_bad = 32'(w_head) >= 32'(NUM_TRACKS) && !w_skip;
  assign w_unused = ^frdata[DATA_W-SAMPLE_W-1:0];
  assign full = w_full;
  assign raddr = r_raddr;
  assign doread = r_doread;
  assign sample_out = r_sample;
  assign sample_valid = r_valid;
  assign cur_idx = r_cur;
  assign done = r_done;
  assign err = r_err;
  assign playing = r_state != IDLE && r_state != DONE;
  always_ff @(posedge clock)
    if (!reset_b) begin
      r_state <= IDLE;
      r_raddr <= '0;
      r_doread <= 1'b0;
      r_sample <= '0;
      r_valid <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_cur <= '0;
      r_rem <= '0;
      r_set <= '0;
`ifdef SPEECH_SEQ_GAP_EN
      r_gap <= '0;
`endif
    end else if (abort) begin
      r_state <= IDLE;
      r_doread <= 1'b0;
      r_sample <= '0;
      r_valid <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE:
          if (start) begin
            r_err <= 1'b0;
            r_state <= FETCH;
          end
        FETCH:
          if (w_empty) begin
            r_done <= 1'b1;
            r_state <= DONE;
          end else if (w_bad) r_err <= 1'b1;
          else if (!w_skip) begin
            r_raddr <= ADDR_W'(track_base(32'(w_head), 32'(BASE_ADDR), 32'(TRACK_LENGTH)));
            r_rem <= RW'(TRACK_LENGTH);
            r_cur <= w_head;
            r_set <= '0;
            r_doread <= 1'b1;
            r_state <= SETTLE;
          end
        SETTLE:
          if (r_set >= SW'(SETTLE_CYC - 1) && !busy) r_state <= PLAY;
          else r_set <= r_set + SW'(r_set < SW'(SETTLE_CYC - 1));
        PLAY:
          if (sample_tick) begin
            r_sample <= frdata[DATA_W-1 -: SAMPLE_W];
            r_valid <= 1'b1;
            r_raddr <= r_raddr + ADDR_W'(1);
            r_rem <= r_rem - RW'(1);
            if (r_rem == RW'(1)) begin
              r_doread <= 1'b0;
`ifdef SPEECH_SEQ_GAP_EN
              r_gap <= GW'(GAP_SAMPLES);
              r_state <= w_empty ? FETCH : GAP;
`else
              r_state <= FETCH;
`endif
            end
          end
`ifdef SPEECH_SEQ_GAP_EN
        GAP:
          if (sample_tick) begin
            r_sample <= '0;
            r_valid <= 1'b1;
            r_gap <= r_gap - GW'(1);
            if (r_gap == GW'(1)) r_state <= FETCH;
          end
`endif
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (push && w_full) r_err <= 1'b1;
    end
endmodule
